data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Single-port 32-bit word memory responder with an optional post-reset zero-fill,
// sticky out-of-range error flag and saturating read/write counters.
module data_mem_responder #(
    parameter int AW           = 10,
    parameter int ENTRY        = 1024,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DREQ,
    input  logic        DRW,
    input  logic [29:0] DADDR,
    input  logic [31:0] DWDATA,
    output logic [31:0] DRDATA,
    output logic        BUSY,
    output logic        ERR,
    output logic [15:0] RD_CNT,
    output logic [15:0] WR_CNT
);

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLR_ON_RESET ? CLEAR : SERVE;
    localparam logic [AW-1:0] LAST_IDX = AW'(ENTRY - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    state_t state, state_nxt;

    logic [AW-1:0]     fill_cnt;
    logic [DATA_W-1:0] mem [ENTRY];

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [AW-1:0]     idx_p0;
    logic              in_range_p0;
    logic              serve_p0;
    logic              wr_ok_p0;
    logic              rd_ok_p0;
    logic              oor_p0;
    logic              oor_rd_p0;

    logic [DATA_W-1:0] rdata_p1;
    logic              err_p1;
    logic [CNT_W-1:0]  rd_cnt_p1;
    logic [CNT_W-1:0]  wr_cnt_p1;

    // Stage p0: request decode against the current FSM state
    assign idx_p0      = DADDR[AW-1:0];
    assign in_range_p0 = (DADDR[29:AW] == '0);
    assign serve_p0    = (state == SERVE) && DREQ;
    assign wr_ok_p0    = serve_p0 && DRW && in_range_p0;
    assign rd_ok_p0    = serve_p0 && !DRW && in_range_p0;
    assign oor_p0      = serve_p0 && !in_range_p0;
    assign oor_rd_p0   = oor_p0 && !DRW;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_waddr = idx_p0;
        mem_wdata = DWDATA;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = fill_cnt;
                mem_wdata = '0;
                if (fill_cnt == LAST_IDX) begin
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                mem_we = wr_ok_p0;
            end
            default: begin
                state_nxt = RESET_STATE;
            end
        endcase
        // A reset edge never touches the array; the fill restarts from index 0
        if (RST) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fill_cnt <= '0;
        end else if (state == CLEAR) begin
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Stage p1: registered read data, error flag and counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_p1 <= '0;
        end else if (rd_ok_p0) begin
            rdata_p1 <= mem[idx_p0];
        end else if (oor_rd_p0) begin
            rdata_p1 <= '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_p1 <= 1'b0;
        end else if (oor_p0) begin
            err_p1 <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_cnt_p1 <= '0;
            wr_cnt_p1 <= '0;
        end else begin
            if (rd_ok_p0) begin
                rd_cnt_p1 <= sat_inc(rd_cnt_p1);
            end
            if (wr_ok_p0) begin
                wr_cnt_p1 <= sat_inc(wr_cnt_p1);
            end
        end
    end

    assign DRDATA = rdata_p1;
    assign BUSY   = (state == CLEAR);
    assign ERR    = err_p1;
    assign RD_CNT = rd_cnt_p1;
    assign WR_CNT = wr_cnt_p1;

endmodule
